// File: rtl/ref_seq_reader_pkg.sv
// rtl/ref_seq_reader_pkg.sv - shared widths, FSM states and sizing helpers for the reference reader
package ref_seq_reader_pkg;

  localparam int ADDR_W = 25;
  localparam int LEN_W  = 25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // counter width for a modulo-n counter, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ref_seq_reader_if.sv
// rtl/ref_seq_reader_if.sv - engine and DRAM read-port signal bundle for the reference reader
interface ref_seq_reader_if #(
  parameter int REF_LENGTH = 128,
  parameter int DRAM_WIDTH = 128
);
  import ref_seq_reader_pkg::*;

  logic [ADDR_W-1:0]       ref_addr_in;
  logic [LEN_W-1:0]        ref_length_in;
  logic                    ref_info_valid_in;
  logic [2*REF_LENGTH-1:0] ref_seq_block_out;
  logic                    ref_seq_block_valid_out;
  logic                    ref_seq_block_rdy_in;
  logic [ADDR_W-1:0]       dram_rd_addr_out;
  logic                    dram_rd_req_out;
  logic                    dram_rd_ack_in;
  logic [DRAM_WIDTH-1:0]   dram_rd_data_in;
  logic                    dram_rd_data_valid_in;
  logic                    busy_out;
  logic                    job_overflow_out;

  // reader side
  modport master (
    input  ref_addr_in, ref_length_in, ref_info_valid_in, ref_seq_block_rdy_in,
    input  dram_rd_ack_in, dram_rd_data_in, dram_rd_data_valid_in,
    output ref_seq_block_out, ref_seq_block_valid_out, dram_rd_addr_out, dram_rd_req_out,
    output busy_out, job_overflow_out
  );

  // engine and DRAM side
  modport slave (
    output ref_addr_in, ref_length_in, ref_info_valid_in, ref_seq_block_rdy_in,
    output dram_rd_ack_in, dram_rd_data_in, dram_rd_data_valid_in,
    input  ref_seq_block_out, ref_seq_block_valid_out, dram_rd_addr_out, dram_rd_req_out,
    input  busy_out, job_overflow_out
  );

endinterface

// File: rtl/ref_block_fifo.sv
// rtl/ref_block_fifo.sv - synchronous first-word-fall-through block FIFO with occupancy count
module ref_block_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // a pop frees the head slot, so a push paired with a pop is legal even when full
  always_comb begin
    do_rd = rd_en & (count != '0);
    do_wr = wr_en & ((count != CW'(DEPTH)) | do_rd);
  end

  // storage is not reset; the head word is only meaningful while not empty
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);

endmodule

// File: rtl/ref_seq_reader.sv
// rtl/ref_seq_reader.sv - reference job intake, credit-limited DRAM reads, block assembly and FIFO output
module ref_seq_reader
  import ref_seq_reader_pkg::*;
#(
  parameter int REF_LENGTH = 128,
  parameter int DRAM_WIDTH = 128,
  parameter int FIFO_DEPTH = 8
) (
  input logic              clk,
  input logic              rst,
  ref_seq_reader_if.master bus
);

  localparam int BLOCK_W = 2 * REF_LENGTH;
  localparam int BEATS   = BLOCK_W / DRAM_WIDTH;
  localparam int CW      = LEN_W + $clog2(BEATS);
  localparam int SW      = cnt_w(BEATS);
  localparam int RW      = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  logic [ADDR_W-1:0]  job_addr;
  logic [CW-1:0]      job_total;
  logic [CW-1:0]      req_idx;
  logic [CW-1:0]      rcv_idx;
  logic [SW-1:0]      req_sub;
  logic [SW-1:0]      asm_cnt;
  logic [RW-1:0]      reserved;
  logic               pend_valid;
  logic [ADDR_W-1:0]  pend_addr;
  logic [LEN_W-1:0]   pend_len;
  logic               overflow;
  logic               rd_req;
  logic [ADDR_W-1:0]  rd_addr;
  logic [BLOCK_W-1:0] asm_data;

  logic               ack, beat0_ack, rcv, push, pop, desc_ok, last_ack, last_rcv;
  logic               fifo_empty;
  logic [RW-1:0]      fifo_count;
  logic [RW-1:0]      reserved_nxt;
  logic [CW-1:0]      req_idx_nxt;
  logic [CW-1:0]      rcv_idx_nxt;
  logic [SW-1:0]      req_sub_nxt;
  logic [ADDR_W-1:0]  ld_addr;
  logic [LEN_W-1:0]   ld_len;
  logic [BLOCK_W-1:0] asm_block;
  logic [BLOCK_W-1:0] fifo_data;

  // handshake decode and the counter values the registered request is computed from
  always_comb begin
    ack          = rd_req & bus.dram_rd_ack_in;
    beat0_ack    = ack & (req_sub == '0);
    rcv          = bus.dram_rd_data_valid_in & (state != ST_IDLE);
    push         = rcv & (asm_cnt == SW'(BEATS - 1));
    pop          = ~fifo_empty & bus.ref_seq_block_rdy_in;
    desc_ok      = bus.ref_info_valid_in & (bus.ref_length_in != '0);
    req_idx_nxt  = req_idx + CW'(ack);
    rcv_idx_nxt  = rcv_idx + CW'(rcv);
    req_sub_nxt  = req_sub;
    if (ack) req_sub_nxt = (req_sub == SW'(BEATS - 1)) ? '0 : req_sub + SW'(1);
    reserved_nxt = reserved + RW'(beat0_ack) - RW'(pop);
    last_ack     = ack & (req_idx_nxt == job_total);
    last_rcv     = rcv & (rcv_idx_nxt == job_total);
    ld_addr      = pend_valid ? pend_addr : bus.ref_addr_in;
    ld_len       = pend_valid ? pend_len : bus.ref_length_in;
    // new beat enters at the top, so after BEATS beats beat 0 sits in the low slot
    asm_block    = BLOCK_W'({bus.dram_rd_data_in, asm_data} >> DRAM_WIDTH);
  end

  // job FSM, pending slot, request/credit counters and beat assembler
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      job_addr   <= '0;
      job_total  <= '0;
      req_idx    <= '0;
      rcv_idx    <= '0;
      req_sub    <= '0;
      asm_cnt    <= '0;
      reserved   <= '0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_len   <= '0;
      overflow   <= 1'b0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
      asm_data   <= '0;
    end else begin
      req_idx  <= req_idx_nxt;
      rcv_idx  <= rcv_idx_nxt;
      req_sub  <= req_sub_nxt;
      reserved <= reserved_nxt;
      if (rcv) begin
        asm_data <= asm_block;
        asm_cnt  <= (asm_cnt == SW'(BEATS - 1)) ? '0 : asm_cnt + SW'(1);
      end
      case (state)
        ST_IDLE: begin
          if (pend_valid || desc_ok) begin
            state     <= ST_REQ;
            job_addr  <= ld_addr;
            job_total <= CW'(ld_len) * CW'(BEATS);
            req_idx   <= '0;
            rcv_idx   <= '0;
            req_sub   <= '0;
            rd_req    <= (reserved_nxt < RW'(FIFO_DEPTH));
            rd_addr   <= ld_addr;
            // a descriptor arriving while the slot is being drained refills it
            pend_valid <= pend_valid & desc_ok;
            if (pend_valid && desc_ok) begin
              pend_addr <= bus.ref_addr_in;
              pend_len  <= bus.ref_length_in;
            end
          end
        end
        default: begin
          if (desc_ok) begin
            if (pend_valid) begin
              overflow <= 1'b1;
            end else begin
              pend_valid <= 1'b1;
              pend_addr  <= bus.ref_addr_in;
              pend_len   <= bus.ref_length_in;
            end
          end
          if (state == ST_REQ) begin
            if (last_ack) begin
              rd_req <= 1'b0;
              state  <= last_rcv ? ST_IDLE : ST_WAIT;
            end else begin
              // only the first beat of a block waits for a free FIFO credit
              rd_req  <= (req_sub_nxt != '0) | (reserved_nxt < RW'(FIFO_DEPTH));
              rd_addr <= job_addr + ADDR_W'(req_idx_nxt);
            end
          end else if (last_rcv) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  ref_block_fifo #(
    .WIDTH (BLOCK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (asm_block),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bus.ref_seq_block_valid_out = ~fifo_empty;
  assign bus.ref_seq_block_out       = fifo_empty ? '0 : fifo_data;
  assign bus.dram_rd_req_out         = rd_req;
  assign bus.dram_rd_addr_out        = rd_addr;
  assign bus.busy_out                = (state != ST_IDLE) | pend_valid | (fifo_count != '0);
  assign bus.job_overflow_out        = overflow;

endmodule

// File: tb/tb_ref_seq_reader.sv
// tb/tb_ref_seq_reader.sv - randomized DRAM/engine environment with a queue-based reference model
module tb_ref_seq_reader;

  localparam int BEATS = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ref_seq_reader_if bus ();

  ref_seq_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [24:0]  exp_addr[$];
  bit           exp_b0[$];
  logic [255:0] exp_blk[$];
  logic [24:0]  ret_addr[$];
  int           ret_due[$];

  int  cyc = 0;
  int  n_hs = 0, n_b0 = 0, n_pop = 0, beats_ret = 0, blocks_done = 0;
  bit  ack_random = 1'b0;
  int  rdy_mode = 1;
  int  lat_min = 1, lat_max = 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] dram_word(input logic [24:0] a);
    logic [31:0] x;
    x = {7'd0, a};
    return {x ^ 32'hDEADBEEF, x * 32'h9E3779B1, ~x, x + 32'h01234567};
  endfunction

  // a job of n blocks reads 2n consecutive words (25-bit wrap); block k = {word 2k+1, word 2k}
  task automatic model_add(input logic [24:0] a, input int n);
    logic [24:0] w0, w1;
    for (int i = 0; i < n * BEATS; i++) begin
      w0 = a + 25'(i);
      exp_addr.push_back(w0);
      exp_b0.push_back((i % BEATS) == 0);
    end
    for (int k = 0; k < n; k++) begin
      w0 = a + 25'(2 * k);
      w1 = a + 25'(2 * k + 1);
      exp_blk.push_back({dram_word(w1), dram_word(w0)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic submit(input logic [24:0] a, input logic [24:0] n, input bit runs);
    bus.ref_addr_in       = a;
    bus.ref_length_in     = n;
    bus.ref_info_valid_in = 1'b1;
    if (runs) model_add(a, int'(n));
    tick();
    bus.ref_info_valid_in = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int  k;
    bit  done;
    k = 0;
    done = 1'b0;
    while (k < budget && !done) begin
      done = (exp_addr.size() == 0) && (exp_blk.size() == 0) && (ret_due.size() == 0) && !bus.busy_out;
      if (!done) begin
        tick();
        k++;
      end
    end
    check({tag, "_drained"}, done, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, bus.dram_rd_req_out, 1'b0);
    check({tag, "_addr"}, bus.dram_rd_addr_out, 25'd0);
    check({tag, "_valid"}, bus.ref_seq_block_valid_out, 1'b0);
    check({tag, "_block"}, bus.ref_seq_block_out, 256'd0);
    check({tag, "_busy"}, bus.busy_out, 1'b0);
    check({tag, "_ovf"}, bus.job_overflow_out, 1'b0);
  endtask

  // DRAM responder and engine sink, acting on the falling edge
  initial begin
    logic [24:0]  ea, ra;
    logic [255:0] held;
    bit           b0, lat_chk, stalled;
    int           due;
    lat_chk = 1'b0;
    stalled = 1'b0;
    held = '0;
    bus.dram_rd_ack_in = 1'b0;
    bus.dram_rd_data_in = '0;
    bus.dram_rd_data_valid_in = 1'b0;
    bus.ref_seq_block_rdy_in = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        bus.dram_rd_ack_in = 1'b0;
        bus.dram_rd_data_valid_in = 1'b0;
        bus.ref_seq_block_rdy_in = 1'b0;
        lat_chk = 1'b0;
        stalled = 1'b0;
      end else begin
        if (lat_chk) check("push_latency", bus.ref_seq_block_valid_out, 1'b1);
        lat_chk = 1'b0;
        if (stalled) begin
          check("hold_valid", bus.ref_seq_block_valid_out, 1'b1);
          check("hold_data", bus.ref_seq_block_out, held);
        end
        bus.dram_rd_data_valid_in = 1'b0;
        if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
          ra = ret_addr.pop_front();
          void'(ret_due.pop_front());
          bus.dram_rd_data_in = dram_word(ra);
          bus.dram_rd_data_valid_in = 1'b1;
          beats_ret++;
          if (beats_ret % BEATS == 0) begin
            if (blocks_done == n_pop) lat_chk = 1'b1;
            blocks_done++;
          end
        end
        bus.dram_rd_ack_in = ack_random ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.dram_rd_req_out && bus.dram_rd_ack_in) begin
          if (exp_addr.size() == 0) begin
            check("req_unexpected", bus.dram_rd_req_out, 1'b0);
          end else begin
            ea = exp_addr.pop_front();
            b0 = exp_b0.pop_front();
            check("req_addr", bus.dram_rd_addr_out, ea);
            if (b0) begin
              check("credit", (n_b0 - n_pop) < DEPTH, 1'b1);
              n_b0++;
            end
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (ret_due.size() > 0 && due <= ret_due[$]) due = ret_due[$] + 1;
            ret_addr.push_back(bus.dram_rd_addr_out);
            ret_due.push_back(due);
            n_hs++;
          end
        end
        case (rdy_mode)
          0:       bus.ref_seq_block_rdy_in = 1'b0;
          1:       bus.ref_seq_block_rdy_in = 1'b1;
          default: bus.ref_seq_block_rdy_in = 1'($urandom_range(0, 1));
        endcase
        if (bus.ref_seq_block_valid_out && bus.ref_seq_block_rdy_in) begin
          if (exp_blk.size() == 0) check("blk_unexpected", bus.ref_seq_block_valid_out, 1'b0);
          else check("block", bus.ref_seq_block_out, exp_blk.pop_front());
          n_pop++;
        end
        stalled = bus.ref_seq_block_valid_out && !bus.ref_seq_block_rdy_in;
        held = bus.ref_seq_block_out;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, pop0, b00, req_cycles, k;
    logic [24:0] a, n;
    bus.ref_addr_in = '0;
    bus.ref_length_in = '0;
    bus.ref_info_valid_in = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("idle_busy", bus.busy_out, 1'b0);

    // three blocks, ack tied high, fixed 2-cycle return, engine always ready
    ack_random = 1'b0; rdy_mode = 1; lat_min = 2; lat_max = 2;
    hs0 = n_hs; pop0 = n_pop;
    submit(25'h100, 25'd3, 1'b1);
    drain("t1", 200);
    check("t1_reqs", n_hs - hs0, 6);
    check("t1_blocks", n_pop - pop0, 3);

    // twenty blocks with the engine stalled: requests stop once the FIFO credit is used up
    rdy_mode = 0; lat_min = 1; lat_max = 4;
    b00 = n_b0; pop0 = n_pop;
    a = 25'($urandom);
    submit(a, 25'd20, 1'b1);
    repeat (80) tick();
    check("t2_beat0_reqs", n_b0 - b00, DEPTH);
    check("t2_stalled_req", bus.dram_rd_req_out, 1'b0);
    check("t2_none_popped", exp_blk.size(), 20);
    rdy_mode = 2;
    drain("t2", 3000);
    check("t2_blocks", n_pop - pop0, 20);

    // address wrap at the top of the 25-bit space
    ack_random = 1'b1;
    submit(25'h1FFFFFE, 25'd2, 1'b1);
    drain("t3", 300);

    // second descriptor pends, third is dropped and flags overflow
    submit(25'($urandom), 25'd6, 1'b1);
    submit(25'($urandom), 25'd2, 1'b1);
    check("t4_no_ovf_yet", bus.job_overflow_out, 1'b0);
    submit(25'($urandom), 25'd3, 1'b0);
    check("t4_ovf", bus.job_overflow_out, 1'b1);
    drain("t4", 1000);
    check("t4_ovf_sticky", bus.job_overflow_out, 1'b1);

    // zero-length descriptor issues nothing
    submit(25'h55, 25'd0, 1'b0);
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.dram_rd_req_out) req_cycles++;
      tick();
    end
    check("t5_no_req", req_cycles, 0);
    check("t5_idle", bus.busy_out, 1'b0);

    // random back-to-back job pairs
    lat_max = 5;
    for (int j = 0; j < 4; j++) begin
      n = 25'($urandom_range(1, 5));
      submit(25'($urandom), n, 1'b1);
      n = 25'($urandom_range(1, 5));
      submit(25'($urandom), n, 1'b1);
      drain("rnd", 1500);
    end

    // reset in the middle of a job with blocks sitting in the FIFO
    ack_random = 1'b0; rdy_mode = 0; lat_min = 1; lat_max = 1;
    submit(25'($urandom), 25'd10, 1'b1);
    k = 0;
    while (k < 200 && blocks_done < 3) begin
      tick();
      k++;
    end
    tick();
    check("t6_fifo_filled", blocks_done >= 3, 1'b1);
    rst = 1'b1;
    exp_addr.delete(); exp_b0.delete(); exp_blk.delete();
    ret_addr.delete(); ret_due.delete();
    n_b0 = 0; n_pop = 0; beats_ret = 0; blocks_done = 0;
    tick();
    check_all_zero("t6_rst");
    rst = 1'b0;
    rdy_mode = 1;
    pop0 = n_pop;
    submit(25'($urandom), 25'd1, 1'b1);
    drain("t6", 200);
    check("t6_blocks", n_pop - pop0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
